// File: rtl/sdram_prbs_checker.sv
// PRBS-16 traffic generator and read-back checker for the SDRAM controller FIFO ports.
// Writes NUM_WORDS words per pass, waits, then reads them back and checks each one.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for sdram_init_done
// INIT_WAIT | settling delay after init_done; drops back if init_done falls
// WRITE     | wr_en high for NUM_WORDS cycles, wr_data = write LFSR
// GAP       | idle while the controller flushes writes and prefetches reads
// READ      | rd_en high for NUM_WORDS cycles
// DRAIN     | lets the last RD_LAT words reach the compare stage
// NEXT      | bump pass_cnt, pick the next seed or finish
// DONE      | sticky until reset
module sdram_prbs_checker #(
  parameter int          NUM_WORDS  = 1024,
  parameter int          GAP_CYCLES = 2000,
  parameter int          INIT_DELAY = 16,
  parameter int          RD_LAT     = 1,
  parameter int          PASSES     = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        error_flag,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_idx,
  output logic [7:0]  pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_WAIT,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  // Zero-length delays are held to one cycle so every timer phase has a terminal count.
  localparam int          PIPE_W     = (RD_LAT > 0) ? RD_LAT : 1;
  localparam logic [15:0] WORDS_LOAD = 16'(NUM_WORDS - 1);
  localparam logic [15:0] INIT_LOAD  = 16'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
  localparam logic [15:0] GAP_LOAD   = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0] DRAIN_LOAD = 16'(PIPE_W - 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  function automatic logic [15:0] pass_seed(input logic [7:0] p);
    logic [15:0] s;
    s = SEED ^ {p, 8'h00};
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         tmr;
  logic [15:0]         tmr_nxt;
  logic                start_pass;
  logic                pass_inc;
  logic                last_pass;
  logic [7:0]          pass_cnt_nxt;
  logic [15:0]         seed_nxt;
  logic [15:0]         wr_lfsr;
  logic [15:0]         rd_lfsr;
  logic [15:0]         cmp_idx;
  logic [PIPE_W-1:0]   cmp_pipe;
  logic                cmp_vld;
  logic                mismatch;

  assign wr_en    = (state == S_WRITE);
  assign rd_en    = (state == S_READ);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign wr_data  = wr_lfsr;

  assign last_pass    = (PASSES != 0) && (({24'd0, pass_cnt} + 32'd1) == 32'(PASSES));
  assign pass_cnt_nxt = pass_inc ? pass_cnt + 8'd1 : pass_cnt;
  assign seed_nxt     = pass_seed(pass_cnt_nxt);

  assign cmp_vld  = cmp_pipe[PIPE_W-1];
  assign mismatch = cmp_vld && (rd_data != rd_lfsr);

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    start_pass = 1'b0;
    pass_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sdram_init_done) begin
          state_nxt = S_INIT_WAIT;
          tmr_nxt   = INIT_LOAD;
        end
      end
      S_INIT_WAIT: begin
        if (!sdram_init_done) begin
          state_nxt = S_IDLE;
        end else if (tmr == 16'd0) begin
          state_nxt  = S_WRITE;
          tmr_nxt    = WORDS_LOAD;
          start_pass = 1'b1;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_WRITE: begin
        if (tmr == 16'd0) begin
          state_nxt = S_GAP;
          tmr_nxt   = GAP_LOAD;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_GAP: begin
        if (tmr == 16'd0) begin
          state_nxt = S_READ;
          tmr_nxt   = WORDS_LOAD;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_READ: begin
        if (tmr == 16'd0) begin
          state_nxt = S_DRAIN;
          tmr_nxt   = DRAIN_LOAD;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_DRAIN: begin
        if (tmr == 16'd0) begin
          state_nxt = S_NEXT;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      S_NEXT: begin
        pass_inc = 1'b1;
        if (last_pass) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt  = S_WRITE;
          tmr_nxt    = WORDS_LOAD;
          start_pass = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmr      <= 16'd0;
      pass_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      pass_cnt <= pass_cnt_nxt;
    end
  end

  // Both generators restart from the pass seed so the read side regenerates the written stream.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      wr_lfsr <= 16'd0;
      rd_lfsr <= 16'd0;
      cmp_idx <= 16'd0;
    end else if (start_pass) begin
      wr_lfsr <= seed_nxt;
      rd_lfsr <= seed_nxt;
      cmp_idx <= 16'd0;
    end else begin
      if (wr_en) begin
        wr_lfsr <= lfsr_step(wr_lfsr);
      end
      if (cmp_vld) begin
        rd_lfsr <= lfsr_step(rd_lfsr);
        cmp_idx <= cmp_idx + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      cmp_pipe <= '0;
    end else begin
      cmp_pipe[0] <= rd_en;
      for (int i = 1; i < PIPE_W; i++) begin
        cmp_pipe[i] <= cmp_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      error_flag    <= 1'b0;
      err_cnt       <= 16'd0;
      first_err_idx <= 16'hFFFF;
    end else if (mismatch) begin
      error_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (first_err_idx == 16'hFFFF) begin
        first_err_idx <= cmp_idx;
      end
    end
  end

endmodule
